// File: rtl/pwm_capture.sv
// pwm_capture: recovers period and high time of an asynchronous PWM input and
// presents the measured duty cycle as a read-only 32-bit processor I/O word.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int DUTY_W  = 10,
  parameter int TIMEOUT = 2048
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pwm_in,
  input  logic              enable,
  input  logic              rd_en,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic [CNT_W-1:0]  period,
  output logic              sample_valid,
  output logic              stuck,
  output logic [31:0]       rd_data
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, STUCK} state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [DUTY_W-1:0] DUTY_MAX    = '1;

  logic              s1, s2, s3;
  logic              rise;
  state_t            state, state_next;
  logic [CNT_W-1:0]  period_cnt, period_cnt_next, period_inc;
  logic [CNT_W-1:0]  high_cnt, high_cnt_next, high_inc;
  logic              load;
  logic [CNT_W-1:0]  load_period;
  logic [DUTY_W-1:0] load_duty, duty_sat;
  logic              load_stuck;
  logic              fresh;

  // Three-flop synchronizer; only s2 and s3 feed the measurement logic.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise       = s2 & ~s3;
  assign period_inc = (period_cnt == CNT_MAX) ? period_cnt : period_cnt + CNT_ONE;
  assign high_inc   = (s2 && high_cnt != CNT_MAX) ? high_cnt + CNT_ONE : high_cnt;
  assign duty_sat   = (high_cnt > CNT_W'(DUTY_MAX)) ? DUTY_MAX : high_cnt[DUTY_W-1:0];

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // The rise cycle itself is counted by reloading to 1, so an ideal P/H input
  // reports exactly P and H at the following rise.
  always_comb begin
    state_next      = state;
    period_cnt_next = period_cnt;
    high_cnt_next   = high_cnt;
    load            = 1'b0;
    load_period     = '0;
    load_duty       = '0;
    load_stuck      = 1'b0;
    if (!enable) begin
      state_next      = IDLE;
      period_cnt_next = '0;
      high_cnt_next   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          period_cnt_next = '0;
          high_cnt_next   = '0;
          state_next      = ARM;
        end
        ARM: begin
          if (rise) begin
            period_cnt_next = CNT_ONE;
            high_cnt_next   = CNT_ONE;
            state_next      = MEASURE;
          end else if (period_cnt >= TIMEOUT_CNT) begin
            load       = 1'b1;
            load_duty  = s2 ? DUTY_MAX : '0;
            load_stuck = 1'b1;
            state_next = STUCK;
          end else begin
            period_cnt_next = period_inc;
          end
        end
        MEASURE: begin
          if (rise) begin
            load            = 1'b1;
            load_period     = period_cnt;
            load_duty       = duty_sat;
            period_cnt_next = CNT_ONE;
            high_cnt_next   = CNT_ONE;
          end else if (period_cnt >= TIMEOUT_CNT) begin
            load       = 1'b1;
            load_duty  = s2 ? DUTY_MAX : '0;
            load_stuck = 1'b1;
            state_next = STUCK;
          end else begin
            period_cnt_next = period_inc;
            high_cnt_next   = high_inc;
          end
        end
        STUCK: begin
          if (rise) begin
            period_cnt_next = CNT_ONE;
            high_cnt_next   = CNT_ONE;
            state_next      = MEASURE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      period_cnt   <= '0;
      high_cnt     <= '0;
      period       <= '0;
      duty_cycle   <= '0;
      stuck        <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      period_cnt   <= period_cnt_next;
      high_cnt     <= high_cnt_next;
      sample_valid <= load;
      if (load) begin
        period     <= load_period;
        duty_cycle <= load_duty;
        stuck      <= load_stuck;
      end
    end
  end

  // A pulse arriving together with a read keeps fresh set so no sample is lost.
  always_ff @(posedge clock) begin
    if (!reset)            fresh <= 1'b0;
    else if (sample_valid) fresh <= 1'b1;
    else if (rd_en)        fresh <= 1'b0;
  end

  assign rd_data = {fresh, stuck, 4'b0000, 16'(period), 10'(duty_cycle)};

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed PWM waveforms with hand-computed reports, checking
// steady capture, duty step, stuck detection, read handshake and reset.
module tb_pwm_capture;

  logic        clock = 1'b0;
  logic        reset, pwm_in, enable, rd_en;
  logic [9:0]  duty_cycle, sat_duty;
  logic [15:0] period, sat_period;
  logic        sample_valid, stuck, sat_valid, sat_stuck;
  logic [31:0] rd_data, sat_rd;

  int assertions = 0;
  int failures   = 0;
  int cycle      = 0;
  int sat_pulses = 0;
  int base;

  typedef struct {
    int cyc;
    int per;
    int duty;
    int stk;
  } report_t;

  report_t reports[$];
  report_t r, rp;

  int exp_duty[9] = '{300, 300, 300, 300, 700, 700, 700, 1023, 100};
  int exp_per[9]  = '{1024, 1024, 1024, 1024, 1024, 1024, 1024, 0, 1024};
  int exp_stk[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
  int exp_gap[9]  = '{0, 1024, 1024, 1024, 1024, 1024, 1024, 2048, 0};

  pwm_capture u_dut (
    .clock(clock), .reset(reset), .pwm_in(pwm_in), .enable(enable), .rd_en(rd_en),
    .duty_cycle(duty_cycle), .period(period), .sample_valid(sample_valid),
    .stuck(stuck), .rd_data(rd_data)
  );

  pwm_capture #(.TIMEOUT(4096)) u_sat (
    .clock(clock), .reset(reset), .pwm_in(pwm_in), .enable(enable), .rd_en(rd_en),
    .duty_cycle(sat_duty), .period(sat_period), .sample_valid(sat_valid),
    .stuck(sat_stuck), .rd_data(sat_rd)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cycle = cycle + 1;

  always @(posedge clock) begin
    #1;
    if (sample_valid)
      reports.push_back('{cycle, int'(period), int'(duty_cycle), int'(stuck)});
    if (sat_valid) sat_pulses = sat_pulses + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic hold_pwm(input logic level, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = level;
      tick();
    end
  endtask

  task automatic applyStimulus(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++) begin
        pwm_in = (i < h);
        tick();
      end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions = assertions + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
               tag, actual, actual, expected, expected);
    end
  endtask

  task automatic get_report(input int idx, output report_t rr);
    if (idx < reports.size()) rr = reports[idx];
    else                      rr = '{-1, -1, -1, -1};
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    rd_en  = 1'b0;
    pwm_in = 1'b0;

    for (int i = 0; i < 4; i++) begin
      pwm_in = i[0];
      tick();
    end
    checkOutput("reset_duty", duty_cycle, 0);
    checkOutput("reset_period", period, 0);
    checkOutput("reset_valid", sample_valid, 0);
    checkOutput("reset_stuck", stuck, 0);
    checkOutput("reset_rd_data", rd_data, 0);

    reset = 1'b1;
    applyStimulus(16, 8, 4);
    checkOutput("idle_no_pulse", reports.size(), 0);
    checkOutput("idle_rd_data", rd_data, 0);

    enable = 1'b1;
    applyStimulus(1024, 300, 4);
    checkOutput("steady_count", reports.size(), 3);

    fork
      applyStimulus(1024, 700, 3);
      begin
        int n;
        repeat (10) tick();
        rd_en = 1'b1;
        checkOutput("rd_alone_fresh", rd_data[31], 1);
        tick();
        rd_en = 1'b0;
        checkOutput("rd_alone_clear", rd_data[31], 0);
        n = 0;
        while (!sample_valid && n < 2000) begin
          tick();
          n++;
        end
        checkOutput("rd_sv_seen", sample_valid, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checkOutput("rd_sv_fresh_kept", rd_data[31], 1);
      end
    join

    hold_pwm(1'b1, 3000);
    checkOutput("stuck_flag", stuck, 1);
    checkOutput("stuck_duty", duty_cycle, 1023);
    checkOutput("stuck_period", period, 0);
    checkOutput("stuck_rd_bit", rd_data[30], 1);
    applyStimulus(1024, 100, 2);
    checkOutput("stuck_through_first_rise", stuck, 1);
    checkOutput("stuck_no_extra", reports.size(), 8);
    applyStimulus(1024, 100, 1);
    checkOutput("stuck_cleared", stuck, 0);
    checkOutput("restart_duty", duty_cycle, 100);
    checkOutput("restart_rd_word", rd_data, 32'h8010_0064);
    checkOutput("report_total", reports.size(), 9);

    for (int i = 0; i < 9; i++) begin
      get_report(i, r);
      checkOutput($sformatf("rep%0d_duty", i), r.duty, exp_duty[i]);
      checkOutput($sformatf("rep%0d_period", i), r.per, exp_per[i]);
      checkOutput($sformatf("rep%0d_stuck", i), r.stk, exp_stk[i]);
      if (exp_gap[i] != 0) begin
        get_report(i - 1, rp);
        checkOutput($sformatf("rep%0d_gap", i), r.cyc - rp.cyc, exp_gap[i]);
      end
    end

    reset = 1'b0;
    hold_pwm(1'b0, 3);
    checkOutput("sat_reset_duty", sat_duty, 0);
    checkOutput("sat_reset_rd", sat_rd, 0);
    reset = 1'b1;
    base  = sat_pulses;
    applyStimulus(2000, 1500, 3);
    hold_pwm(1'b1, 5);
    checkOutput("sat_count", sat_pulses - base, 3);
    checkOutput("sat_duty", sat_duty, 1023);
    checkOutput("sat_period", sat_period, 2000);
    checkOutput("sat_stuck", sat_stuck, 0);

    hold_pwm(1'b1, 1495);
    hold_pwm(1'b0, 200);
    reset = 1'b0;
    hold_pwm(1'b0, 3);
    checkOutput("midreset_duty", sat_duty, 0);
    checkOutput("midreset_period", sat_period, 0);
    checkOutput("midreset_rd", sat_rd, 0);
    checkOutput("midreset_main_rd", rd_data, 0);
    reset = 1'b1;
    base  = sat_pulses;
    hold_pwm(1'b0, 297);
    applyStimulus(2000, 1500, 1);
    checkOutput("sat_arm_discard", sat_pulses - base, 0);
    hold_pwm(1'b1, 5);
    checkOutput("sat_after_reset_count", sat_pulses - base, 1);
    checkOutput("sat_after_reset_duty", sat_duty, 1023);
    checkOutput("sat_after_reset_period", sat_period, 2000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
